host_cmd_hub: RTL and testbench
===============================

Name: host_cmd_hub

Overview:
- Upstream front end of LogicCaptureTop.
- Converts a host byte stream (from the UART receiver) into command/commandStrobe/regIn0..7 transactions.
- Performs the ack/CMD_ACK handshake with the capture core and returns each result as a fixed-length response frame on a byte stream to the UART transmitter.
- Replaces the simulation-only command generator in the real design.

Parameters:
- ACK_TIMEOUT_CLKS, 1000000, max clocks to wait for status[3] to assert, or to clear after CMD_ACK.
- RX_TIMEOUT_CLKS, 100000, max clocks between consecutive bytes of one host frame.
- TIMER_W, 24, width of the shared timeout counter; must hold the larger timeout.

Ports:
- clk, input, 1, system clock.
- resetn, input, 1, reset.
- rx_data, input, 8, host byte.
- rx_valid, input, 1, one-cycle pulse: rx_data valid.
- tx_data, output, 8, response byte.
- tx_valid, output, 1, response byte valid; held until accepted.
- tx_ready, input, 1, transmitter accepts byte when tx_valid&&tx_ready.
- command, output, 8, function code to capture core.
- commandStrobe, output, 1, one-cycle command strobe.
- regIn0..regIn7, output, 8 each, argument registers to capture core.
- regOut0..regOut7, input, 8 each, result registers from capture core.
- status, input, 8, core status; bit0 idle, bit3 ack.
- rx_dropped, output, 1, one-cycle pulse when a byte arrives while busy.
- busy, output, 1, high in any state other than IDLE/RX_PAYLOAD.

Behaviour:
- Reset is resetn, synchronous, active-low; clock is clk. All outputs are 0 during reset (command=CMD_NOP, tx_valid=0, regIn*=0) and the FSM goes to IDLE. Reset mid-frame discards all partial rx/tx state.
- Host frame: 9 bytes = opcode, then payload bytes p0..p7 mapping to regIn0..regIn7.
- Response frame: 11 bytes = opcode echo, result, status snapshot, regOut0..regOut7.
- Result codes: 00 OK, 01 BAD_OPCODE, 02 ACK_TIMEOUT.
- Valid host opcodes: 00–07 and 09. Opcode 08 (CMD_ACK) and opcodes above 09 are BAD_OPCODE.
- IDLE: on rx_valid, latch opcode, clear byte index, go to RX_PAYLOAD.
- RX_PAYLOAD:
  - Each rx_valid stores a byte into the shadow buffer and restarts the timer.
  - After the 8th byte: go to ISSUE if the opcode is valid, else load the response with result 01 and regOut fields 00, and go to TX.
  - If the timer reaches RX_TIMEOUT_CLKS, discard the frame silently and return to IDLE.
- ISSUE (1 cycle):
  - regIn0..7 <= shadow buffer; command <= opcode; commandStrobe=1. Go to WAIT_ACK.
  - regIn* change only in this cycle and otherwise hold their value.
- WAIT_ACK:
  - When status[3]=1: capture regOut0..7 and status into the response buffer with result 00, then go to SEND_ACK.
  - If the timer hits ACK_TIMEOUT_CLKS: result 02, regOut fields 00, go to TX. No CMD_ACK is issued.
- SEND_ACK (1 cycle): command <= CMD_ACK (08); commandStrobe=1. Go to WAIT_CLR.
- WAIT_CLR:
  - Wait for status[3]=0, then go to TX.
  - Timeout: overwrite result with 02 (captured data kept), go to TX.
- TX:
  - Present bytes 0..10 in order. Advance only on tx_valid&&tx_ready.
  - After byte 10 is accepted, go to IDLE. Earliest next frame byte is accepted the following cycle.
- Strobe timing: commandStrobe is high exactly one cycle per ISSUE/SEND_ACK. command holds its last value until the next strobe.
- Dropped bytes: rx_valid in any state except IDLE/RX_PAYLOAD is dropped and pulses rx_dropped the same cycle.
- Timer: the shared counter is cleared on every state entry and saturates; no wrap-around.
- Simultaneous events: ack on the same cycle as timeout counts as ack.

Decomposition:
- Package hub_pkg holds:
  - CMD_* opcodes 00–09;
  - RES_OK/RES_BAD_OPCODE/RES_ACK_TIMEOUT;
  - REQ_LEN=9 and RSP_LEN=11;
  - the state enum;
  - STATUS_IDLE_BIT=0 and STATUS_ACK_BIT=3.
- Sub-module hub_tx_serializer: 11x8 response buffer load port plus valid/ready byte output with index counter and done pulse.

Test Plan:
- Frame 04 6E 00 00 00 14 00 00 00, core acks after 5 clks with regOut=11..18:
  - regIn0..7 = 6E 00 00 00 14 00 00 00 at the strobe;
  - command 04 then 08 strobed;
  - response 04 00 <status> 11 12 13 14 15 16 17 18.
- Frame with opcode 08 plus 8 bytes: no commandStrobe; response 08 01 <status> then eight 00 bytes.
- Frame 01 plus 8 bytes, ack never asserts: exactly one strobe; response 01 02 … after ACK_TIMEOUT_CLKS; no CMD_ACK strobe.
- Send 4 bytes, then idle for RX_TIMEOUT_CLKS+1: no response; a following full valid frame processes normally.
- tx_ready low for 10 cycles mid-response: tx_data/tx_valid stable while stalled; all 11 bytes are delivered in order.
- Extra byte during WAIT_ACK: rx_dropped pulses once; the current transaction completes unchanged.
- resetn low during WAIT_ACK: all outputs zero next cycle; FSM returns to IDLE.

Source files
------------

// File: rtl/hub_pkg.sv
// Shared opcodes, result codes, frame layouts and FSM states for the host command hub.
package hub_pkg;

  localparam int unsigned REQ_LEN         = 9;
  localparam int unsigned RSP_LEN         = 11;
  localparam int unsigned PAYLOAD_LEN     = REQ_LEN - 1;
  localparam int unsigned RSP_IDX_W       = 4;
  localparam int unsigned STATUS_IDLE_BIT = 0;
  localparam int unsigned STATUS_ACK_BIT  = 3;

  localparam logic [7:0] CMD_NOP         = 8'h00;
  localparam logic [7:0] CMD_RESET       = 8'h01;
  localparam logic [7:0] CMD_ARM         = 8'h02;
  localparam logic [7:0] CMD_READ_ID     = 8'h03;
  localparam logic [7:0] CMD_SET_TRIGGER = 8'h04;
  localparam logic [7:0] CMD_SET_DIVIDER = 8'h05;
  localparam logic [7:0] CMD_SET_COUNT   = 8'h06;
  localparam logic [7:0] CMD_READ_DATA   = 8'h07;
  localparam logic [7:0] CMD_ACK         = 8'h08;
  localparam logic [7:0] CMD_ABORT       = 8'h09;

  localparam logic [7:0] RES_OK          = 8'h00;
  localparam logic [7:0] RES_BAD_OPCODE  = 8'h01;
  localparam logic [7:0] RES_ACK_TIMEOUT = 8'h02;

  typedef enum logic [2:0] {
    ST_IDLE, ST_RX_PAYLOAD, ST_ISSUE, ST_WAIT_ACK, ST_SEND_ACK, ST_WAIT_CLR, ST_TX
  } hubState_t;

  // Element n carries register n (regIn n / regOut n).
  typedef logic [PAYLOAD_LEN-1:0][7:0] payload_t;

  typedef struct packed {
    logic [7:0] opcode;
    logic [7:0] result;
    logic [7:0] status;
    payload_t   regs;
  } rspFrame_t;

  // Byte i of the response in wire order: opcode, result, status, regOut0..7.
  function automatic logic [7:0] rspByte(input rspFrame_t f, input logic [RSP_IDX_W-1:0] i);
    if (i == RSP_IDX_W'(0))      rspByte = f.opcode;
    else if (i == RSP_IDX_W'(1)) rspByte = f.result;
    else if (i == RSP_IDX_W'(2)) rspByte = f.status;
    else                         rspByte = f.regs[3'(i - RSP_IDX_W'(3))];
  endfunction

  // CMD_ACK is reserved for the handshake and may not come from the host.
  function automatic logic opcodeValid(input logic [7:0] op);
    opcodeValid = (op <= CMD_READ_DATA) || (op == CMD_ABORT);
  endfunction

endpackage

// File: rtl/hub_tx_serializer.sv
// Holds one response frame and streams it out byte by byte over valid/ready.
module hub_tx_serializer
  import hub_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       load,
  input  rspFrame_t  frame,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       done_c
);

  rspFrame_t              buffer;
  logic [RSP_IDX_W-1:0]   idx;
  logic                   lastByte;

  assign lastByte = (idx == RSP_IDX_W'(RSP_LEN - 1));
  assign done_c   = tx_valid && tx_ready && lastByte;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      buffer   <= '0;
      idx      <= '0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
    end else if (load) begin
      buffer   <= frame;
      idx      <= '0;
      tx_valid <= 1'b1;
      tx_data  <= rspByte(frame, RSP_IDX_W'(0));
    end else if (tx_valid && tx_ready) begin
      if (lastByte) begin
        tx_valid <= 1'b0;
        idx      <= '0;
      end else begin
        idx     <= idx + RSP_IDX_W'(1);
        tx_data <= rspByte(buffer, idx + RSP_IDX_W'(1));
      end
    end
  end

endmodule

// File: rtl/host_cmd_hub.sv
// Host byte-stream front end: parses command frames, runs the strobe/ack handshake
// with the capture core and returns a fixed-length response frame.
module host_cmd_hub
  import hub_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT_CLKS = 1000000,
  parameter int unsigned RX_TIMEOUT_CLKS  = 100000,
  parameter int unsigned TIMER_W          = 24
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] command,
  output logic       commandStrobe,
  output logic [7:0] regIn0, regIn1, regIn2, regIn3, regIn4, regIn5, regIn6, regIn7,
  input  logic [7:0] regOut0, regOut1, regOut2, regOut3, regOut4, regOut5, regOut6, regOut7,
  input  logic [7:0] status,
  output logic       rx_dropped,
  output logic       busy
);

  localparam int unsigned       BYTE_IDX_W = 3;
  localparam logic [TIMER_W-1:0] RX_LIMIT  = TIMER_W'(RX_TIMEOUT_CLKS - 1);
  localparam logic [TIMER_W-1:0] ACK_LIMIT = TIMER_W'(ACK_TIMEOUT_CLKS - 1);
  localparam logic [TIMER_W-1:0] TIMER_MAX = '1;

  hubState_t              state, nextState;
  logic [TIMER_W-1:0]     timer;
  logic [BYTE_IDX_W-1:0]  byteIdx;
  logic [7:0]             opcode;
  payload_t               shadow, payloadMerged, regInQ, regOutBus;
  rspFrame_t              rsp;
  logic                   loadRsp, txDone_c;
  logic                   ackSeen, rxTimeout, ackTimeout, lastByte;
  logic                   latchOp, storeByte, issueNow, sendAckNow;
  logic                   loadBad, captureAck, ackExpired, clrExpired;

  assign regOutBus  = {regOut7, regOut6, regOut5, regOut4, regOut3, regOut2, regOut1, regOut0};
  assign {regIn7, regIn6, regIn5, regIn4, regIn3, regIn2, regIn1, regIn0} = regInQ;
  assign ackSeen    = status[STATUS_ACK_BIT];
  assign rxTimeout  = (timer >= RX_LIMIT);
  assign ackTimeout = (timer >= ACK_LIMIT);
  assign lastByte   = (byteIdx == BYTE_IDX_W'(PAYLOAD_LEN - 1));
  // Bytes arriving mid-transaction are reported in the cycle they arrive.
  assign rx_dropped = rx_valid && busy;

  always_ff @(posedge clk) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      ST_IDLE:       if (rx_valid) nextState = ST_RX_PAYLOAD;
      ST_RX_PAYLOAD: begin
        if (rx_valid && lastByte)     nextState = opcodeValid(opcode) ? ST_ISSUE : ST_TX;
        else if (!rx_valid && rxTimeout) nextState = ST_IDLE;
      end
      ST_ISSUE:      nextState = ST_WAIT_ACK;
      ST_WAIT_ACK: begin
        if (ackSeen)         nextState = ST_SEND_ACK;
        else if (ackTimeout) nextState = ST_TX;
      end
      ST_SEND_ACK:   nextState = ST_WAIT_CLR;
      ST_WAIT_CLR:   if (!ackSeen || ackTimeout) nextState = ST_TX;
      ST_TX:         if (txDone_c) nextState = ST_IDLE;
      default:       nextState = ST_IDLE;
    endcase
  end

  always_comb begin
    latchOp       = 1'b0;
    storeByte     = 1'b0;
    issueNow      = 1'b0;
    sendAckNow    = 1'b0;
    loadBad       = 1'b0;
    captureAck    = 1'b0;
    ackExpired    = 1'b0;
    clrExpired    = 1'b0;
    payloadMerged = shadow;
    payloadMerged[byteIdx] = rx_data;
    unique case (state)
      ST_IDLE:       latchOp = rx_valid;
      ST_RX_PAYLOAD: begin
        storeByte = rx_valid;
        issueNow  = rx_valid && lastByte && opcodeValid(opcode);
        loadBad   = rx_valid && lastByte && !opcodeValid(opcode);
      end
      ST_WAIT_ACK: begin
        captureAck = ackSeen;
        sendAckNow = ackSeen;
        ackExpired = !ackSeen && ackTimeout;
      end
      ST_WAIT_CLR:   clrExpired = ackSeen && ackTimeout;
      default: ;
    endcase
  end

  // Outputs are loaded on the edge entering ISSUE/SEND_ACK so the core sees them with the strobe.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      timer         <= '0;
      byteIdx       <= '0;
      opcode        <= CMD_NOP;
      shadow        <= '0;
      regInQ        <= '0;
      command       <= CMD_NOP;
      commandStrobe <= 1'b0;
      busy          <= 1'b0;
      rsp           <= '0;
      loadRsp       <= 1'b0;
    end else begin
      commandStrobe <= issueNow || sendAckNow;
      busy          <= !(nextState == ST_IDLE || nextState == ST_RX_PAYLOAD);
      loadRsp       <= (nextState == ST_TX) && (state != ST_TX);
      if (nextState != state || storeByte) timer <= '0;
      else if (timer != TIMER_MAX)         timer <= timer + TIMER_W'(1);
      if (latchOp) begin
        opcode  <= rx_data;
        byteIdx <= '0;
      end
      if (storeByte) begin
        shadow[byteIdx] <= rx_data;
        byteIdx         <= byteIdx + BYTE_IDX_W'(1);
      end
      if (issueNow) begin
        regInQ  <= payloadMerged;
        command <= opcode;
      end
      if (sendAckNow) command <= CMD_ACK;
      if (loadBad)
        rsp <= '{opcode: opcode, result: RES_BAD_OPCODE, status: status, regs: '0};
      if (captureAck)
        rsp <= '{opcode: opcode, result: RES_OK, status: status, regs: regOutBus};
      if (ackExpired)
        rsp <= '{opcode: opcode, result: RES_ACK_TIMEOUT, status: status, regs: '0};
      if (clrExpired) rsp.result <= RES_ACK_TIMEOUT;
    end
  end

  hub_tx_serializer u_txSer (
    .clk      (clk),
    .resetn   (resetn),
    .load     (loadRsp),
    .frame    (rsp),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .done_c   (txDone_c)
  );

endmodule

// File: tb/tb_host_cmd_hub.sv
// Directed bench for host_cmd_hub with a small behavioural capture-core responder.
module tb_host_cmd_hub;

  localparam int unsigned ACK_TO = 40;
  localparam int unsigned RX_TO  = 20;

  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] command;
  logic       commandStrobe;
  logic [7:0] regIn [8];
  logic [7:0] regOut [8];
  logic [7:0] status;
  logic       rx_dropped;
  logic       busy;

  always #5 clk = ~clk;

  host_cmd_hub #(.ACK_TIMEOUT_CLKS(ACK_TO), .RX_TIMEOUT_CLKS(RX_TO), .TIMER_W(24)) dut (
    .clk(clk), .resetn(resetn), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .command(command), .commandStrobe(commandStrobe),
    .regIn0(regIn[0]), .regIn1(regIn[1]), .regIn2(regIn[2]), .regIn3(regIn[3]),
    .regIn4(regIn[4]), .regIn5(regIn[5]), .regIn6(regIn[6]), .regIn7(regIn[7]),
    .regOut0(regOut[0]), .regOut1(regOut[1]), .regOut2(regOut[2]), .regOut3(regOut[3]),
    .regOut4(regOut[4]), .regOut5(regOut[5]), .regOut6(regOut[6]), .regOut7(regOut[7]),
    .status(status), .rx_dropped(rx_dropped), .busy(busy)
  );

  int unsigned nChecks = 0;
  int unsigned nFails  = 0;
  int unsigned cyc = 0;
  logic [7:0]  cmdQ[$];
  logic [7:0]  rspQ[$];
  logic [63:0] regInAtIssue = '0;
  int unsigned issueCyc = 0;
  int unsigned firstTxCyc = 0;
  int unsigned dropCount = 0;
  logic        ackEnable = 1'b1;
  int unsigned ackDelay = 5;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] cmdAt(input int i);
    if (i < cmdQ.size()) return cmdQ[i];
    return 8'hxx;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Observe strobes, accepted response bytes and drop pulses away from the active edge.
  always @(negedge clk) begin
    if (commandStrobe) begin
      cmdQ.push_back(command);
      if (command != 8'h08) begin
        regInAtIssue = {regIn[0], regIn[1], regIn[2], regIn[3], regIn[4], regIn[5], regIn[6], regIn[7]};
        issueCyc = cyc;
      end
    end
    if (tx_valid && tx_ready) begin
      if (rspQ.size() == 0) firstTxCyc = cyc;
      rspQ.push_back(tx_data);
    end
    if (rx_dropped) dropCount++;
  end

  // Capture core stand-in: raises ack ackDelay clocks after a command, drops it after CMD_ACK.
  initial begin
    int unsigned ackCnt, clrCnt;
    status = 8'h01;
    ackCnt = 0;
    clrCnt = 0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        status = 8'h01; ackCnt = 0; clrCnt = 0;
      end else if (commandStrobe && command == 8'h08) begin
        clrCnt = 2;
      end else if (commandStrobe && ackEnable) begin
        ackCnt = ackDelay;
      end else begin
        if (ackCnt == 1) status = 8'h08;
        if (ackCnt > 0) ackCnt--;
        if (clrCnt == 1) status = 8'h01;
        if (clrCnt > 0) clrCnt--;
      end
    end
  end

  task automatic clearMon();
    cmdQ.delete();
    rspQ.delete();
    dropCount = 0;
  endtask

  task automatic sendBytes(input logic [71:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      rx_data  = f[71-8*i -: 8];
      rx_valid = 1'b1;
      tick();
    end
    rx_valid = 1'b0;
  endtask

  task automatic waitStrobes(input string tag, input int n);
    int unsigned waited = 0;
    while (cmdQ.size() < n && waited < 200) begin tick(); waited++; end
    if (cmdQ.size() < n) check({tag, " strobe wait"}, cmdQ.size(), n);
  endtask

  task automatic expectRsp(input string tag, input logic [87:0] exp);
    logic [87:0] got;
    int unsigned waited = 0;
    while (rspQ.size() < 11 && waited < 500) begin tick(); waited++; end
    tick(); tick();
    check({tag, " rsp count"}, rspQ.size(), 11);
    got = '0;
    for (int i = 0; i < 11 && i < rspQ.size(); i++) got[87-8*i -: 8] = rspQ[i];
    check({tag, " rsp bytes"}, got, exp);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned stableErr;
    logic [7:0]  heldData;
    logic        heldValid;
    int unsigned waited;

    resetn = 1'b0; rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) regOut[i] = 8'h11 + 8'(i);
    repeat (3) tick();
    check("reset command", command, 8'h00);
    check("reset strobe", commandStrobe, 1'b0);
    check("reset tx_valid", tx_valid, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset regIn0", regIn[0], 8'h00);
    resetn = 1'b1;
    repeat (2) tick();

    // Normal transaction with ack after 5 clocks.
    clearMon(); ackEnable = 1'b1; ackDelay = 5;
    sendBytes(72'h04_6E_00_00_00_14_00_00_00, 9);
    expectRsp("ok04", {8'h04, 8'h00, 8'h08, 64'h11_12_13_14_15_16_17_18});
    check("ok04 strobes", cmdQ.size(), 2);
    check("ok04 cmd0", cmdAt(0), 8'h04);
    check("ok04 cmd1", cmdAt(1), 8'h08);
    check("ok04 regIn at strobe", regInAtIssue, 64'h6E_00_00_00_14_00_00_00);
    check("ok04 regIn4 held", regIn[4], 8'h14);
    check("ok04 idle after", busy, 1'b0);
    check("ok04 no drops", dropCount, 0);
    repeat (3) tick();

    // Host tries to send CMD_ACK: rejected without touching the core.
    clearMon();
    sendBytes(72'h08_01_02_03_04_05_06_07_08, 9);
    expectRsp("bad08", {8'h08, 8'h01, 8'h01, 64'h0});
    check("bad08 strobes", cmdQ.size(), 0);
    repeat (3) tick();

    // Core never acks: one strobe, timeout response, no CMD_ACK.
    clearMon(); ackEnable = 1'b0;
    sendBytes(72'h01_A1_A2_A3_A4_A5_A6_A7_A8, 9);
    expectRsp("ackto", {8'h01, 8'h02, 8'h01, 64'h0});
    check("ackto strobes", cmdQ.size(), 1);
    check("ackto cmd0", cmdAt(0), 8'h01);
    check("ackto latency", (firstTxCyc - issueCyc >= ACK_TO) && (firstTxCyc - issueCyc <= ACK_TO + 4), 1'b1);
    repeat (3) tick();

    // Partial frame abandoned by the inter-byte timeout, then a clean frame.
    clearMon(); ackEnable = 1'b1; ackDelay = 5;
    sendBytes(72'h02_01_02_03_00_00_00_00_00, 4);
    repeat (RX_TO + 1) tick();
    check("rxto no rsp", rspQ.size(), 0);
    check("rxto no strobe", cmdQ.size(), 0);
    check("rxto busy", busy, 1'b0);
    sendBytes(72'h02_C0_C1_C2_C3_C4_C5_C6_C7, 9);
    expectRsp("rxto next", {8'h02, 8'h00, 8'h08, 64'h11_12_13_14_15_16_17_18});
    check("rxto next regIn", regInAtIssue, 64'hC0_C1_C2_C3_C4_C5_C6_C7);
    check("rxto next strobes", cmdQ.size(), 2);
    repeat (3) tick();

    // Transmitter stall for 10 cycles after the 4th response byte.
    clearMon();
    sendBytes(72'h05_10_20_30_40_50_60_70_80, 9);
    waited = 0;
    while (rspQ.size() < 4 && waited < 200) begin tick(); waited++; end
    tx_ready = 1'b0;
    heldData = tx_data; heldValid = tx_valid;
    stableErr = 0;
    repeat (10) begin
      tick();
      if (tx_data !== heldData || tx_valid !== heldValid) stableErr++;
    end
    check("stall stable", stableErr, 0);
    check("stall valid held", heldValid, 1'b1);
    check("stall no accept", rspQ.size(), 4);
    tx_ready = 1'b1;
    expectRsp("stall", {8'h05, 8'h00, 8'h08, 64'h11_12_13_14_15_16_17_18});
    repeat (3) tick();

    // Stray byte while waiting for ack is dropped and leaves the transaction intact.
    clearMon(); ackDelay = 10;
    sendBytes(72'h03_01_01_01_01_01_01_01_01, 9);
    waitStrobes("drop", 1);
    tick(); tick();
    rx_data = 8'hAA; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    expectRsp("drop", {8'h03, 8'h00, 8'h08, 64'h11_12_13_14_15_16_17_18});
    check("drop count", dropCount, 1);
    check("drop strobes", cmdQ.size(), 2);
    repeat (3) tick();

    // Reset in WAIT_ACK clears everything; next frame runs normally.
    clearMon(); ackEnable = 1'b0;
    sendBytes(72'h06_5A_5B_5C_5D_5E_5F_60_61, 9);
    waitStrobes("rst", 1);
    repeat (3) tick();
    check("rst pre busy", busy, 1'b1);
    resetn = 1'b0;
    tick();
    check("rst command", command, 8'h00);
    check("rst strobe", commandStrobe, 1'b0);
    check("rst tx_valid", tx_valid, 1'b0);
    check("rst tx_data", tx_data, 8'h00);
    check("rst busy", busy, 1'b0);
    check("rst regIn0", regIn[0], 8'h00);
    check("rst regIn7", regIn[7], 8'h00);
    resetn = 1'b1;
    tick();
    clearMon(); ackEnable = 1'b1; ackDelay = 5;
    sendBytes(72'h07_F0_F1_F2_F3_F4_F5_F6_F7, 9);
    expectRsp("post rst", {8'h07, 8'h00, 8'h08, 64'h11_12_13_14_15_16_17_18});
    check("post rst regIn", regInAtIssue, 64'hF0_F1_F2_F3_F4_F5_F6_F7);

    $display("[TB] %0d tests run, %0d failed", nChecks, nFails);
    $finish;
  end

endmodule
